pipeline_ctrl: RTL and testbench

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipeline_ctrl_pkg.sv | 10 +
 rtl/pipeline_ctrl_perf_counter.sv | 18 +
 rtl/pipeline_ctrl.sv | 122 ++++++++++++
 tb/tb_pipeline_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline control block: FSM state encoding.
package pipe_types;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        MEM_STALL = 2'd1,
        REDIRECT  = 2'd2
    } pipe_ctrl_state_t;

endpackage

// File: rtl/pipeline_ctrl_perf_counter.sv
// Free-running wrap-around event counter, cleared by asynchronous active-low reset.
module perf_counter #(
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc,
    output logic [CNT_WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            count <= '0;
        else if (inc)
            count <= count + 1'b1;
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush controller: memory stalls, branch redirects, load-use hazards.
// Optional performance counters are built when PIPE_PERF_CNT_EN is defined.
module pipeline_ctrl
    import pipe_types::*;
#(
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hazard_stall,
    input  logic             br_taken,
    input  logic             icache_read,
    input  logic             icache_resp,
    input  logic             dcache_read,
    input  logic             dcache_write,
    input  logic             dcache_resp,
    output logic             load_pc,
    output logic             if_id_load,
    output logic             id_ex_load,
    output logic             ex_mem_load,
    output logic             mem_wb_load,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output pipe_ctrl_state_t state_o
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0] mem_stall_cnt,
    output logic [CNT_WIDTH-1:0] hazard_cnt,
    output logic [CNT_WIDTH-1:0] redirect_cnt
`endif
);

    pipe_ctrl_state_t state, state_next;
    logic             redirect_pend;
    logic             mem_busy;
    logic             redirect_fire;
    logic             hazard_fire;

    assign mem_busy = (icache_read & ~icache_resp)
                    | ((dcache_read | dcache_write) & ~dcache_resp);
    assign state_o  = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= RUN;
            redirect_pend <= 1'b0;
        end else begin
            state <= state_next;
            // A redirect seen while memory is busy is remembered until the stall ends.
            if (br_taken && mem_busy)
                redirect_pend <= 1'b1;
            else if (redirect_fire)
                redirect_pend <= 1'b0;
        end
    end

    always_comb begin
        state_next    = RUN;
        load_pc       = 1'b1;
        if_id_load    = 1'b1;
        id_ex_load    = 1'b1;
        ex_mem_load   = 1'b1;
        mem_wb_load   = 1'b1;
        flush_if_id   = 1'b0;
        flush_id_ex   = 1'b0;
        redirect_fire = 1'b0;
        hazard_fire   = 1'b0;

        if (!rst) begin
            load_pc     = 1'b0;
            if_id_load  = 1'b0;
            id_ex_load  = 1'b0;
            ex_mem_load = 1'b0;
            mem_wb_load = 1'b0;
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
        end else if (mem_busy) begin
            load_pc     = 1'b0;
            if_id_load  = 1'b0;
            id_ex_load  = 1'b0;
            ex_mem_load = 1'b0;
            mem_wb_load = 1'b0;
            state_next  = MEM_STALL;
        end else if (state == REDIRECT) begin
            flush_if_id = 1'b1;
        end else if (br_taken || redirect_pend) begin
            flush_if_id   = 1'b1;
            flush_id_ex   = 1'b1;
            redirect_fire = 1'b1;
            state_next    = REDIRECT;
        end else if (hazard_stall) begin
            load_pc     = 1'b0;
            if_id_load  = 1'b0;
            flush_id_ex = 1'b1;
            hazard_fire = 1'b1;
        end
    end

`ifdef PIPE_PERF_CNT_EN
    perf_counter #(.CNT_WIDTH(CNT_WIDTH)) u_mem_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (mem_busy),
        .count (mem_stall_cnt)
    );

    perf_counter #(.CNT_WIDTH(CNT_WIDTH)) u_hazard_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (hazard_fire),
        .count (hazard_cnt)
    );

    perf_counter #(.CNT_WIDTH(CNT_WIDTH)) u_redirect_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (redirect_fire),
        .count (redirect_cnt)
    );
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed vector bench for pipeline_ctrl; counter checks compiled in with PIPE_PERF_CNT_EN.
module tb_pipeline_ctrl;
    import pipe_types::*;

    logic clk = 1'b0;
    logic rst;
    logic hazard_stall, br_taken, icache_read, icache_resp;
    logic dcache_read, dcache_write, dcache_resp;
    logic load_pc, if_id_load, id_ex_load, ex_mem_load, mem_wb_load;
    logic flush_if_id, flush_id_ex;
    pipe_ctrl_state_t state_o;
`ifdef PIPE_PERF_CNT_EN
    logic [31:0] mem_stall_cnt, hazard_cnt, redirect_cnt;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pipeline_ctrl #(.CNT_WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .hazard_stall (hazard_stall),
        .br_taken     (br_taken),
        .icache_read  (icache_read),
        .icache_resp  (icache_resp),
        .dcache_read  (dcache_read),
        .dcache_write (dcache_write),
        .dcache_resp  (dcache_resp),
        .load_pc      (load_pc),
        .if_id_load   (if_id_load),
        .id_ex_load   (id_ex_load),
        .ex_mem_load  (ex_mem_load),
        .mem_wb_load  (mem_wb_load),
        .flush_if_id  (flush_if_id),
        .flush_id_ex  (flush_id_ex),
        .state_o      (state_o)
`ifdef PIPE_PERF_CNT_EN
        ,
        .mem_stall_cnt(mem_stall_cnt),
        .hazard_cnt   (hazard_cnt),
        .redirect_cnt (redirect_cnt)
`endif
    );

    // Input bits: {hazard, br, icr, icresp, dcr, dcw, dcresp}
    localparam logic [6:0] I_IDLE = 7'b0000000;
    localparam logic [6:0] I_HAZ  = 7'b1000000;
    localparam logic [6:0] I_BR   = 7'b0100000;
    localparam logic [6:0] I_ICR  = 7'b0010000;
    localparam logic [6:0] I_ICRS = 7'b0001000;
    localparam logic [6:0] I_DCR  = 7'b0000100;
    localparam logic [6:0] I_DCW  = 7'b0000010;
    localparam logic [6:0] I_DCRS = 7'b0000001;

    // Output bits: {load_pc, if_id, id_ex, ex_mem, mem_wb, flush_if_id, flush_id_ex}
    localparam logic [6:0] O_ALL   = 7'b1111100;
    localparam logic [6:0] O_HAZ   = 7'b0011101;
    localparam logic [6:0] O_MEM   = 7'b0000000;
    localparam logic [6:0] O_REDIR = 7'b1111111;
    localparam logic [6:0] O_RDR2  = 7'b1111110;
    localparam logic [6:0] O_RESET = 7'b0000011;

    typedef struct {
        logic [6:0]       in;
        pipe_ctrl_state_t st;
        logic [6:0]       out;
        int unsigned      ms, hz, rd;
    } vec_t;

    vec_t tbl [30];

    function automatic logic [6:0] outs();
        return {load_pc, if_id_load, id_ex_load, ex_mem_load, mem_wb_load,
                flush_if_id, flush_id_ex};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [6:0] v);
        {hazard_stall, br_taken, icache_read, icache_resp,
         dcache_read, dcache_write, dcache_resp} = v;
    endtask

    task automatic check_cnt(input string tag, input int unsigned ms,
                             input int unsigned hz, input int unsigned rd);
`ifdef PIPE_PERF_CNT_EN
        check({tag, " mem_stall_cnt"}, mem_stall_cnt, ms);
        check({tag, " hazard_cnt"},    hazard_cnt,    hz);
        check({tag, " redirect_cnt"},  redirect_cnt,  rd);
`else
        if (ms + hz + rd > 32'hffff_ffff) $display("%s", tag);
`endif
    endtask

    initial begin
        tbl[0]  = '{I_IDLE,               RUN,       O_ALL,   0, 0, 0};
        tbl[1]  = '{I_HAZ,                RUN,       O_HAZ,   0, 1, 0};
        tbl[2]  = '{I_IDLE,               RUN,       O_ALL,   0, 1, 0};
        tbl[3]  = '{I_DCR,                RUN,       O_MEM,   1, 1, 0};
        tbl[4]  = '{I_DCR,                MEM_STALL, O_MEM,   2, 1, 0};
        tbl[5]  = '{I_DCR,                MEM_STALL, O_MEM,   3, 1, 0};
        tbl[6]  = '{I_DCR,                MEM_STALL, O_MEM,   4, 1, 0};
        tbl[7]  = '{I_DCR|I_DCRS,         MEM_STALL, O_ALL,   4, 1, 0};
        tbl[8]  = '{I_IDLE,               RUN,       O_ALL,   4, 1, 0};
        tbl[9]  = '{I_BR,                 RUN,       O_REDIR, 4, 1, 1};
        tbl[10] = '{I_BR|I_HAZ,           REDIRECT,  O_RDR2,  4, 1, 1};
        tbl[11] = '{I_IDLE,               RUN,       O_ALL,   4, 1, 1};
        tbl[12] = '{I_ICR|I_BR,           RUN,       O_MEM,   5, 1, 1};
        tbl[13] = '{I_ICR,                MEM_STALL, O_MEM,   6, 1, 1};
        tbl[14] = '{I_ICR,                MEM_STALL, O_MEM,   7, 1, 1};
        tbl[15] = '{I_ICR|I_ICRS,         MEM_STALL, O_REDIR, 7, 1, 2};
        tbl[16] = '{I_IDLE,               REDIRECT,  O_RDR2,  7, 1, 2};
        tbl[17] = '{I_IDLE,               RUN,       O_ALL,   7, 1, 2};
        tbl[18] = '{I_ICR|I_DCW,          RUN,       O_MEM,   8, 1, 2};
        tbl[19] = '{I_ICR|I_ICRS|I_DCW,   MEM_STALL, O_MEM,   9, 1, 2};
        tbl[20] = '{I_DCW|I_DCRS,         MEM_STALL, O_ALL,   9, 1, 2};
        tbl[21] = '{I_DCR|I_HAZ,          RUN,       O_MEM,  10, 1, 2};
        tbl[22] = '{I_DCR|I_DCRS|I_HAZ,   MEM_STALL, O_HAZ,  10, 2, 2};
        tbl[23] = '{I_IDLE,               RUN,       O_ALL,  10, 2, 2};
        tbl[24] = '{I_BR,                 RUN,       O_REDIR,10, 2, 3};
        tbl[25] = '{I_DCR,                REDIRECT,  O_MEM,  11, 2, 3};
        tbl[26] = '{I_DCR|I_DCRS,         MEM_STALL, O_ALL,  11, 2, 3};
        tbl[27] = '{I_IDLE,               RUN,       O_ALL,  11, 2, 3};
        tbl[28] = '{I_ICR|I_ICRS|I_HAZ,   RUN,       O_HAZ,  11, 3, 3};
        tbl[29] = '{I_IDLE,               RUN,       O_ALL,  11, 3, 3};

        // Reset held for three cycles
        drive(I_IDLE);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk); #1;
            check("reset outs", 32'(outs()), 32'(O_RESET));
            check("reset state", 32'(state_o), 32'(RUN));
        end
        check_cnt("reset", 0, 0, 0);
        rst = 1'b1;

        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            drive(tbl[i].in);
            #1;
            check($sformatf("row%0d outs", i), 32'(outs()), 32'(tbl[i].out));
            check($sformatf("row%0d state", i), 32'(state_o), 32'(tbl[i].st));
            @(posedge clk); #1;
            check_cnt($sformatf("row%0d", i), tbl[i].ms, tbl[i].hz, tbl[i].rd);
        end

        // Reset mid-MEM_STALL with a redirect pending
        @(negedge clk); drive(I_ICR | I_BR);
        @(negedge clk); drive(I_ICR);
        #1 check("pend stall state", 32'(state_o), 32'(MEM_STALL));
        rst = 1'b0;
        #1;
        check("pend reset outs", 32'(outs()), 32'(O_RESET));
        check("pend reset state", 32'(state_o), 32'(RUN));
        check_cnt("pend reset", 0, 0, 0);
        @(negedge clk); drive(I_IDLE); rst = 1'b1;
        repeat (2) begin
            #1;
            check("post reset outs", 32'(outs()), 32'(O_ALL));
            check("post reset state", 32'(state_o), 32'(RUN));
            @(negedge clk);
        end
        check_cnt("post reset", 0, 0, 0);

        // Reset mid-REDIRECT
        drive(I_BR);
        @(negedge clk); drive(I_IDLE);
        #1 check("redir state", 32'(state_o), 32'(REDIRECT));
        rst = 1'b0;
        @(negedge clk); rst = 1'b1;
        #1;
        check("redir reset outs", 32'(outs()), 32'(O_ALL));
        check("redir reset state", 32'(state_o), 32'(RUN));
        @(negedge clk); #1;
        check("redir reset next", 32'(outs()), 32'(O_ALL));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
